// File: rtl/beam_forming_tdoa.sv
// Sign-correlation TDOA estimator: scores 2*MAX_LAG+1 candidate inter-channel lags over a
// window of sign bits and publishes the best lag as a one-hot LED direction indication.
module beam_forming_tdoa #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LAG    = 3,
  parameter int WINDOW     = 64,
  parameter int LED_WIDTH  = 8,
  parameter int MIN_SCORE  = WINDOW / 2,
  localparam int L         = 2 * MAX_LAG + 1,
  localparam int LAG_W     = $clog2(MAX_LAG + 1) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   left_data_in,
  input  logic [DATA_WIDTH-1:0]   right_data_in,
  output logic [LED_WIDTH-1:0]    led_pattern,
  output logic signed [LAG_W-1:0] best_lag,
  output logic                    beam_locked,
  output logic                    beam_forming_valid
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {FILL, ACCUM, SCAN, OUTPUT} state_e;

  state_e                  state_q, state_d;
  logic [L-1:0]            lsr_q, lsr_d, rsr_q, rsr_d;
  logic [L-1:0]            match;
  logic [CNT_W-1:0]        score_q [L];
  logic [CNT_W-1:0]        score_d [L];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        best_score_q, best_score_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [LED_WIDTH-1:0]    led_q, led_d;
  logic signed [LAG_W-1:0] lag_q, lag_d;
  logic                    locked_q, locked_d;
  logic                    valid_q, valid_d;

  // Only the sign bits are used; fold the magnitudes into a deliberately unused net.
  logic unused_magnitude;
  assign unused_magnitude = ^{left_data_in[DATA_WIDTH-2:0], right_data_in[DATA_WIDTH-2:0]};

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves a signal unassigned (no latch).
    state_d      = state_q;
    lsr_d        = lsr_q;
    rsr_d        = rsr_q;
    score_d      = score_q;
    cnt_d        = cnt_q;
    best_score_d = best_score_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    led_d        = led_q;
    lag_d        = lag_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
    match        = '0;

    if (sample_valid) begin
      lsr_d = {lsr_q[L-2:0], left_data_in[DATA_WIDTH-1]};
      rsr_d = {rsr_q[L-2:0], right_data_in[DATA_WIDTH-1]};
    end

    // Lag k compares the centre of the left history with right tap MAX_LAG+k (post-shift).
    for (int j = 0; j < L; j++) begin
      match[j] = (lsr_d[MAX_LAG] == rsr_d[j]);
    end

    case (state_q)
      FILL: begin
        if (sample_valid) begin
          if (cnt_q == CNT_W'(2 * MAX_LAG - 1)) begin
            state_d = ACCUM;
            cnt_d   = '0;
            for (int j = 0; j < L; j++) score_d[j] = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ACCUM: begin
        if (sample_valid) begin
          for (int j = 0; j < L; j++) begin
            score_d[j] = score_q[j] + CNT_W'(match[j]);
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WINDOW - 1)) begin
            state_d    = SCAN;
            scan_idx_d = '0;
          end
        end
      end
      SCAN: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if (scan_idx_q == '0 || score_q[scan_idx_q] > best_score_q) begin
          best_score_d = score_q[scan_idx_q];
          best_idx_d   = scan_idx_q;
        end
        if (scan_idx_q == IDX_W'(L - 1)) begin
          state_d = OUTPUT;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      OUTPUT: begin
        valid_d = 1'b1;
        lag_d   = LAG_W'(int'(best_idx_q) - MAX_LAG);
        if (int'(best_score_q) >= MIN_SCORE) begin
          led_d    = LED_WIDTH'(1) << best_idx_q;
          locked_d = 1'b1;
        end else begin
          led_d    = '0;
          locked_d = 1'b0;
        end
        cnt_d = '0;
        for (int j = 0; j < L; j++) score_d[j] = '0;
        state_d = ACCUM;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state updates use <= only; the score array is a handful of flops, so it is reset too.
      state_q      <= FILL;
      lsr_q        <= '0;
      rsr_q        <= '0;
      for (int j = 0; j < L; j++) score_q[j] <= '0;
      cnt_q        <= '0;
      best_score_q <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      led_q        <= '0;
      lag_q        <= '0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsr_q        <= lsr_d;
      rsr_q        <= rsr_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      best_score_q <= best_score_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      led_q        <= led_d;
      lag_q        <= lag_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
    end
  end

  assign led_pattern        = led_q;
  assign best_lag           = lag_q;
  assign beam_locked        = locked_q;
  assign beam_forming_valid = valid_q;

endmodule
